// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller and the stack memory it drives.
package stack_pkg;

  localparam int STACK_DEPTH = 32;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_t;

  localparam logic [3:0] MEM_IDLE = 4'h0;
  localparam logic [3:0] MEM_WR   = 4'h1;
  localparam logic [3:0] MEM_RD   = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Downward-growing stack pointer and push/pop/peek sequencer in front of stack_memory.
// One request in flight at a time; a single capture register holds push data, then the response.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DEPTH  = STACK_DEPTH,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] esp,
  output logic              full,
  output logic              empty,
  output logic [3:0]        mem_rw,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

  state_t            state, state_nxt;
  op_t               op_in, op_q;
  logic [DATA_W-1:0] esp_q, data_q, addr_q, wdata_q;
  logic              err_q, req_err;

  assign op_in = op_t'(op_code);
  assign esp   = esp_q;
  assign full  = (esp_q == '0);
  assign empty = (esp_q == DEPTH_W);

  // Bounds are checked against the registered esp before any update, so esp never wraps.
  assign req_err = ((op_in == OP_PUSH) && full) ||
                   (((op_in == OP_POP) || (op_in == OP_PEEK)) && empty);

  assign rsp_data = rsp_valid ? data_q : '0;
  assign rsp_err  = rsp_valid & err_q;

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_nxt = state;
    op_ready  = 1'b0;
    rsp_valid = 1'b0;
    mem_rw    = MEM_IDLE;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          case (op_in)
            OP_PUSH:         state_nxt = full  ? ST_RESP : ST_WRITE;
            OP_POP, OP_PEEK: state_nxt = empty ? ST_RESP : ST_READ;
            default:         state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: begin
        mem_rw    = MEM_WR;
        mem_addr  = esp_q - ONE;
        mem_wdata = data_q;
        state_nxt = ST_RESP;
      end
      ST_READ: begin
        mem_rw    = MEM_RD;
        mem_addr  = esp_q;
        state_nxt = ST_RDWAIT;
      end
      ST_RDWAIT: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      esp_q   <= DEPTH_W;
      op_q    <= OP_NOP;
      data_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // Address/data pins hold whatever was last driven once the access is over.
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_q   <= op_in;
            data_q <= req_err ? '0 : op_data;
            err_q  <= req_err;
          end
        end
        ST_WRITE: esp_q <= esp_q - ONE;
        ST_RDWAIT: begin
          data_q <= mem_rdata;
          if (op_q == OP_POP) esp_q <= esp_q + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: queue-based stack model with per-cycle comparison,
// a 1-cycle-read memory model, and directed vectors with hand-computed results.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int DEPTH = STACK_DEPTH;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] op_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] esp;
  logic        full;
  logic        empty;
  logic [3:0]  mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  stack_ctrl #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_data(op_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .esp(esp), .full(full), .empty(empty),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural stack memory: write on command 1, registered read on command 2.
  logic [31:0] mem [DEPTH];
  always @(posedge clock) begin
    if (mem_rw == 4'h1 && mem_addr < DEPTH) mem[mem_addr[4:0]] <= mem_wdata;
    else if (mem_rw == 4'h2 && mem_addr < DEPTH) mem_rdata <= mem[mem_addr[4:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the stack contents as a queue, plus the expected timeline of the request in flight.
  typedef struct {
    int          tag;        // cycle index of the first cycle after the accept edge
    int          rsp;        // cycle index where rsp_valid is expected
    logic [31:0] esp_before;
    logic [31:0] esp_after;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  mem;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] stk[$];
  txn_t        rec;

  task automatic model_clear();
    stk.delete();
    rec.tag = 0; rec.rsp = -1;
    rec.esp_before = DEPTH; rec.esp_after = DEPTH;
    rec.rdata = '0; rec.err = 1'b0; rec.mem = 4'h0; rec.addr = '0; rec.wdata = '0;
  endtask

  task automatic model_accept(input logic [1:0] op, input logic [31:0] d);
    rec.tag        = cyc + 1;
    rec.esp_before = DEPTH - stk.size();
    rec.mem        = 4'h0;
    rec.err        = 1'b0;
    rec.rdata      = '0;
    if (op == OP_PUSH) begin
      if (stk.size() == DEPTH) begin
        rec.err = 1'b1; rec.rsp = rec.tag;
      end else begin
        stk.push_back(d);
        rec.rsp = rec.tag + 1; rec.rdata = d;
        rec.mem = 4'h1; rec.addr = rec.esp_before - 1; rec.wdata = d;
      end
    end else begin
      if (stk.size() == 0) begin
        rec.err = 1'b1; rec.rsp = rec.tag;
      end else begin
        rec.rdata = (op == OP_POP) ? stk.pop_back() : stk[$];
        rec.rsp = rec.tag + 2;
        rec.mem = 4'h2; rec.addr = rec.esp_before;
      end
    end
    rec.esp_after = DEPTH - stk.size();
  endtask

  // Per-cycle comparison against the model timeline.
  bit          in_win;
  bit          esp_chk;
  logic [31:0] exp_esp;
  always @(negedge clock) begin
    if (chk_en) begin
      in_win = (cyc >= rec.tag) && (cyc <= rec.rsp);
      check("op_ready", op_ready, !in_win);
      check("rsp_valid", rsp_valid, cyc == rec.rsp);
      if (cyc == rec.rsp) begin
        check("rsp_data", rsp_data, rec.rdata);
        check("rsp_err", rsp_err, rec.err);
      end
      esp_chk = 1'b1;
      exp_esp = rec.esp_after;
      if (cyc < rec.tag) exp_esp = rec.esp_before;
      else if (cyc < rec.rsp) esp_chk = 1'b0;
      if (esp_chk) begin
        check("esp", esp, exp_esp);
        check("full", full, exp_esp == 0);
        check("empty", empty, exp_esp == DEPTH);
      end
      if (cyc == rec.tag && rec.mem != 4'h0) begin
        check("mem_rw", mem_rw, rec.mem);
        check("mem_addr", mem_addr, rec.addr);
        if (rec.mem == 4'h1) check("mem_wdata", mem_wdata, rec.wdata);
      end else begin
        check("mem_rw_idle", mem_rw, 4'h0);
      end
    end
  end

  // Present a request at the next ready cycle; while busy, op_valid stays high with junk to
  // show that requests are not queued.
  task automatic issue(input logic [1:0] op, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!op_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", op_ready, 1);
    op_valid = 1'b1; op_code = op; op_data = d;
    if (op != OP_NOP) model_accept(op, d);
    @(posedge clock);
    #1;
    if (op != OP_NOP) begin
      op_code = OP_PUSH; op_data = 32'hBAD0_BAD0;
    end else begin
      op_valid = 1'b0; op_code = OP_NOP; op_data = '0;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] d, input logic [31:0] e_data,
                     input logic e_err, input int e_lat, input logic [31:0] e_esp);
    int k;
    issue(op, d);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!rsp_valid && k < 8);
    op_valid = 1'b0; op_code = OP_NOP; op_data = '0;
    check("rsp_seen", rsp_valid, 1);
    check("latency", k, e_lat);
    check("lit_rsp_data", rsp_data, e_data);
    check("lit_rsp_err", rsp_err, e_err);
    check("lit_esp", esp, e_esp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = OP_NOP; op_data = '0;
    model_clear();
    #12;
    check("rst_esp", esp, 32);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_op_ready", op_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_esp", esp, 32);

    // Single push, then peek and pop of the same word.
    run(OP_PUSH, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2, 31);
    run(OP_PEEK, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 31);
    run(OP_POP,  32'h0, 32'hDEAD_BEEF, 1'b0, 3, 32);
    check("empty_after_pop", empty, 1);

    // Underflow on an empty stack, and a NOP that must produce nothing.
    run(OP_POP,  32'h0, 32'h0, 1'b1, 1, 32);
    run(OP_PEEK, 32'h0, 32'h0, 1'b1, 1, 32);
    issue(OP_NOP, 32'h5555_5555);
    repeat (3) @(negedge clock);
    check("nop_esp", esp, 32);

    // Fill to the top, overflow once, then drain in LIFO order.
    for (int i = 0; i < 32; i++) run(OP_PUSH, i, i, 1'b0, 2, 31 - i);
    check("full_flag", full, 1);
    check("full_empty_flag", empty, 0);
    run(OP_PUSH, 32'h1234_5678, 32'h0, 1'b1, 1, 0);
    for (int i = 0; i < 32; i++) run(OP_POP, 32'h0, 31 - i, 1'b0, 3, i + 1);
    check("drained_empty", empty, 1);

    // Reset in the RDWAIT cycle of a pop aborts without a response.
    run(OP_PUSH, 32'h0000_0007, 32'h0000_0007, 1'b0, 2, 31);
    issue(OP_POP, 32'h0);
    @(negedge clock);
    check("abort_read_cmd", mem_rw, 4'h2);
    @(negedge clock);
    #2;
    chk_en = 1'b0;
    op_valid = 1'b0; op_code = OP_NOP;
    reset = 1'b1;
    #1;
    check("abort_esp", esp, 32);
    check("abort_op_ready", op_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_mem_rw", mem_rw, 0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    chk_en = 1'b1;
    @(negedge clock);
    check("post_reset_ready", op_ready, 1);
    repeat (4) @(negedge clock);
    run(OP_POP, 32'h0, 32'h0, 1'b1, 1, 32);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Stack-pointer and push/pop sequencer sitting directly upstream of `stack_memory`. It accepts PUSH/POP/PEEK requests from the execute stage over a valid/ready handshake, owns `esp`, and drives the stack memory's command, address and write-data pins. It also returns popped or peeked data and flags overflow and underflow. The stack grows downward, x86 style: empty is `esp == DEPTH`, full is `esp == 0`.

## Interface
- `DEPTH`, default 32: number of 32-bit stack words. Must match the `stack_memory` array size.
- `DATA_W`, default 32: data and `esp` width.

- `clock` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `op_valid` in 1: request present.
- `op_ready` out 1: controller can accept a request. High only in IDLE.
- `op_code` in 2: 2'b00 NOP, 2'b01 PUSH, 2'b10 POP, 2'b11 PEEK.
- `op_data` in 32: value to push.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_data` out 32: popped or peeked value; pushed value for PUSH; 0 on error.
- `rsp_err` out 1: qualifies `rsp_valid`. Overflow on PUSH, underflow on POP/PEEK.
- `esp` out 32: current stack pointer, a word index.
- `full` out 1: `esp == 0`.
- `empty` out 1: `esp == DEPTH`.
- `mem_rw` out 4: 4'h0 idle, 4'h1 write, 4'h2 read. Connects to `read_or_write`.
- `mem_addr` out 32: connects to the memory's `esp` address pin.
- `mem_wdata` out 32: connects to `write_data`.
- `mem_rdata` in 32: memory read data. Valid one cycle after a 4'h2 command.

## Operation
- **States:** IDLE, WRITE, READ, RDWAIT, RESP.
- **IDLE:** `op_ready = 1`. A transfer occurs when `op_valid & op_ready`, and `op_code`/`op_data` are captured into registers.
  - NOP: accepted, stay in IDLE, no response.
  - PUSH with `full`: go to RESP with `rsp_err = 1`. No memory access.
  - PUSH otherwise: go to WRITE.
  - POP/PEEK with `empty`: go to RESP with `rsp_err = 1`.
  - POP/PEEK otherwise: go to READ.
- **WRITE:**
  - Drive `mem_rw = 4'h1`, `mem_addr = esp - 1`, `mem_wdata = captured data`.
  - At the end of the cycle `esp <= esp - 1`. Go to RESP.
- **READ:** drive `mem_rw = 4'h2`, `mem_addr = esp`. Go to RDWAIT.
- **RDWAIT:**
  - Drive `mem_rw = 4'h0` and capture `mem_rdata`.
  - POP: `esp <= esp + 1`. PEEK: `esp` unchanged.
  - Go to RESP.
- **RESP:** `rsp_valid = 1` for exactly one cycle with `rsp_data`/`rsp_err`, then go to IDLE.
- On error, `esp`, `full` and `empty` are unchanged.
- **Outside WRITE/READ:** `mem_rw = 4'h0`, and `mem_addr`/`mem_wdata` hold their last values.
- **Arithmetic:** `esp` is 32-bit unsigned and only ever takes values 0..DEPTH. Bounds are checked before any update, so it never wraps.
- **Illegal state encodings** return to IDLE.

## Timing
- **Reset values:**
  - `esp = DEPTH`, `empty = 1`, `full = 0`
  - `op_ready = 1` (state IDLE)
  - `rsp_valid = 0`, `rsp_err = 0`, `rsp_data = 0`
  - `mem_rw = 4'h0`, `mem_addr = 0`, `mem_wdata = 0`
- **Latency, counting the accept edge as cycle 0:**
  - PUSH: WRITE in cycle 1, `rsp_valid` in cycle 2.
  - POP/PEEK: READ in cycle 1, RDWAIT in cycle 2, `rsp_valid` in cycle 3.
  - Errors: `rsp_valid` in cycle 1.
- **Throughput:** the next request is accepted in the cycle after RESP. `op_ready` is low from the accept edge until IDLE is re-entered.
- **Stable signals:** `full`/`empty` are combinational from registered `esp`, so they are stable for the whole IDLE cycle.
- **Reset mid-operation:** asserting `reset` in any state aborts immediately. There is no response, `esp` returns to DEPTH, and `mem_rw` goes to 4'h0 asynchronously. A memory write in flight at that edge is not guaranteed.
- **Input sampling:** `op_valid` while `op_ready = 0` is ignored, not queued. Inputs are sampled only at the accept edge.

## Structure
- Shared package `stack_pkg` holds:
  - op codes (`OP_NOP`, `OP_PUSH`, `OP_POP`, `OP_PEEK`)
  - memory command codes (`MEM_IDLE` 4'h0, `MEM_WR` 4'h1, `MEM_RD` 4'h2)
  - FSM state encoding
  - `STACK_DEPTH` = 32, used by both this block and `stack_memory`.
- No sub-module. The block is a single FSM plus an `esp` register and a capture register.
- Test bench pairs the block with a behavioural 1-cycle-read memory model.

## Test plan
- Reset, then idle 5 cycles → `esp = 32`, `empty = 1`, `mem_rw = 0` throughout.
- PUSH 32'hDEAD_BEEF → WRITE cycle with `mem_addr = 31`, `mem_wdata = DEADBEEF`; `rsp_valid` in cycle 2; `esp = 31`.
- Then PEEK followed by POP → both return DEADBEEF with `rsp_valid` at cycle 3. `esp` is 31 after the PEEK and 32 after the POP; `empty = 1`.
- 32 PUSHes of values 0..31 → `full = 1`, `esp = 0`. A 33rd PUSH gives `rsp_err = 1` at cycle 1, no write, `esp = 0`. Then 32 POPs return 31..0.
- POP on an empty stack → `rsp_err = 1`, `rsp_data = 0`, `esp = 32`, `mem_rw` never 4'h2.
- Reset asserted during RDWAIT of a POP → no `rsp_valid`, `esp = 32`, `op_ready = 1` immediately after reset deasserts.
